// File: rtl/uart_prog_loader.sv
// uart_prog_loader: pops a 'L' + 16-bit count + little-endian word stream from the
// UART RX FIFO, writes the words to consecutive imem addresses, then ACKs/NAKs via TX.
module uart_prog_loader #(
  parameter int                DATA_W   = 8,
  parameter int                INSTR_W  = 32,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] CMD_LOAD = 8'h4C,
  parameter logic [DATA_W-1:0] ACK_BYTE = 8'h06,
  parameter logic [DATA_W-1:0] NAK_BYTE = 8'h15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [DATA_W-1:0]  i_rx_data,
  input  logic               i_rx_empty,
  output logic               o_rx_rd,
  input  logic               i_tx_full,
  output logic               o_tx_wr,
  output logic [DATA_W-1:0]  o_tx_data,
  output logic               o_imem_we,
  output logic [ADDR_W-1:0]  o_imem_addr,
  output logic [INSTR_W-1:0] o_imem_wdata,
  output logic               o_busy,
  output logic               o_load_done
);
  typedef enum logic [3:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_CHECK, S_DATA, S_WRITE, S_ACK, S_NAK, S_DONE
  } state_t;
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
  state_t                    r_state, w_next;
  logic [15:0]               r_cnt;
  logic [ADDR_W:0]           r_idx;
  logic [1:0]                r_byte;
  logic [INSTR_W-DATA_W-1:0] r_sh;
  logic [INSTR_W-1:0]        r_wdata;
  logic [ADDR_W-1:0]         r_addr;
  logic                      w_pop, w_tx_wr, w_last;
  logic [ADDR_W:0]           w_idx_nx;
  assign w_pop = (r_state == S_IDLE || r_state == S_CNT_LO || r_state == S_CNT_HI ||
                  r_state == S_DATA) && !i_rx_empty;
  assign w_tx_wr  = (r_state == S_ACK || r_state == S_NAK) && !i_tx_full;
  assign w_idx_nx = r_idx + (ADDR_W+1)'(1);
  assign w_last   = 16'(w_idx_nx) == r_cnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = (w_pop && i_rx_data == CMD_LOAD) ? S_CNT_LO : S_IDLE;
      S_CNT_LO: w_next = w_pop ? S_CNT_HI : S_CNT_LO;
      S_CNT_HI: w_next = w_pop ? S_CHECK : S_CNT_HI;
      S_CHECK:  w_next = (r_cnt == 16'd0) ? S_ACK : ({1'b0, r_cnt} > CAP) ? S_NAK : S_DATA;
      S_DATA:   w_next = (w_pop && r_byte == 2'd3) ? S_WRITE : S_DATA;
      S_WRITE:  w_next = w_last ? S_ACK : S_DATA;
      S_ACK:    w_next = i_tx_full ? S_ACK : S_DONE;
      S_NAK:    w_next = i_tx_full ? S_NAK : S_IDLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // The finished word and its address are latched with the 4th byte so they stay stable after WRITE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_sh    <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CNT_LO && w_pop) r_cnt[7:0] <= i_rx_data;
      if (r_state == S_CNT_HI && w_pop) r_cnt[15:8] <= i_rx_data;
      if (r_state == S_CHECK) begin
        r_idx  <= '0;
        r_byte <= '0;
      end
      if (r_state == S_DATA && w_pop) begin
        r_sh   <= {i_rx_data, r_sh[INSTR_W-DATA_W-1:DATA_W]};
        r_byte <= r_byte + 2'd1;
        if (r_byte == 2'd3) begin
          r_wdata <= {i_rx_data, r_sh};
          r_addr  <= r_idx[ADDR_W-1:0];
        end
      end
      if (r_state == S_WRITE) r_idx <= w_idx_nx;
    end
  end
  assign o_rx_rd      = w_pop;
  assign o_tx_wr      = w_tx_wr;
  assign o_tx_data    = !w_tx_wr ? '0 : (r_state == S_NAK) ? NAK_BYTE : ACK_BYTE;
  assign o_imem_we    = r_state == S_WRITE;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_busy       = r_state != S_IDLE;
  assign o_load_done  = r_state == S_DONE;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: random byte streams through a FWFT RX model; a stream-level
// parser predicts imem writes, TX bytes and load_done pulses into a scoreboard queue.
module tb_uart_prog_loader;
  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;
  typedef logic [7:0] bq_t[$];
  typedef struct {int kind; logic [31:0] a; logic [31:0] d;} ev_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_empty = 1'b1, i_tx_full = 1'b0;
  logic        o_rx_rd, o_tx_wr, o_imem_we, o_busy, o_load_done;
  logic [7:0]  o_tx_data;
  logic [7:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;
  ev_t         exq[$];
  ev_t         e;
  int          checks = 0, errors = 0, cyc = 0, last_pop = -10, last_tx = -10;
  uart_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty),
    .o_rx_rd(o_rx_rd), .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_busy(o_busy), .o_load_done(o_load_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t x;
    x.kind = kind; x.a = a; x.d = d;
    exq.push_back(x);
  endtask
  // Reference: parse the whole byte stream; kinds 0=imem write, 1=tx byte, 2=load_done.
  task automatic model(input bq_t b);
    int i = 0;
    int n;
    while (i < b.size()) begin
      if (b[i] != 8'h4C) begin i++; continue; end
      if (i + 2 >= b.size()) break;
      n = {b[i+2], b[i+1]};
      i += 3;
      if (n > CAP) begin
        push(1, 0, 32'h15);
        continue;
      end
      for (int w = 0; w < n; w++) begin
        push(0, w, {b[i+3], b[i+2], b[i+1], b[i]});
        i += 4;
      end
      push(1, 0, 32'h06);
      push(2, 0, 0);
    end
  endtask
  task automatic send(input bq_t b, input int gap);
    int t, g;
    foreach (b[k]) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin @(negedge clk); i_rx_empty = 1'b1; end
      @(negedge clk); i_rx_data = b[k]; i_rx_empty = 1'b0; #1;
      t = 0;
      while (!o_rx_rd && t < 100) begin @(negedge clk); #1; t++; end
      if (t >= 100) begin
        checks++; errors++;
        $display("FAIL rx_pop_timeout: byte %0d not popped after %0d cycles, required <100", k, t);
      end
      @(posedge clk);
    end
    @(negedge clk); i_rx_empty = 1'b1;
  endtask
  task automatic drain();
    int t = 0;
    while ((exq.size() != 0 || o_busy) && t < 400) begin @(negedge clk); #2; t++; end
    if (t >= 400) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d events pending, busy=%0b", exq.size(), o_busy);
    end
    chk("busy_idle", o_busy, 0);
  endtask
  task automatic pop_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    if (exq.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: kind %0d a=%h d=%h, required none", kind, a, d);
    end else begin
      e = exq.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_addr", a, e.a);
      chk("event_data", d, e.d);
    end
  endtask
  always begin
    @(negedge clk); #2;
    if (!rst) begin
      cyc++;
      if (o_rx_rd && i_rx_empty) chk("rx_rd_while_empty", 1, 0);
      if (o_tx_wr && i_tx_full) chk("tx_wr_while_full", 1, 0);
      if (o_imem_we) begin
        chk("we_after_pop", cyc - last_pop, 1);
        pop_ev(0, {24'h0, o_imem_addr}, o_imem_wdata);
      end
      if (o_tx_wr) begin
        pop_ev(1, 0, {24'h0, o_tx_data});
        last_tx = cyc;
      end
      if (o_load_done) begin
        chk("done_after_tx", cyc - last_tx, 1);
        pop_ev(2, 0, 0);
      end
      if (o_rx_rd) last_pop = cyc;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bq_t c1, s;
    int n;
    c1 = {8'h4C, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    repeat (3) @(negedge clk);
    #2;
    chk("rst_rx_rd", o_rx_rd, 0);
    chk("rst_tx", {o_tx_wr, o_tx_data}, 0);
    chk("rst_imem", {o_imem_we, o_imem_addr, o_imem_wdata}, 0);
    chk("rst_status", {o_busy, o_load_done}, 0);
    @(negedge clk); rst = 1'b0;
    model(c1); send(c1, 0); drain();
    s = {8'h4C, 8'h00, 8'h00};
    model(s); send(s, 0); drain();
    s = {8'h4C, 8'h01, 8'h01};
    model(s); send(s, 0); drain();
    s = {8'h41, 8'hFF};
    s = {s, c1};
    model(s); send(s, 3); drain();
    i_tx_full = 1'b1;
    model(c1); send(c1, 0);
    repeat (10) @(negedge clk);
    #2;
    chk("bp_pending", exq.size(), 2);
    @(negedge clk); i_tx_full = 1'b0;
    drain();
    s = {8'h4C, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send(s, 0);
    @(negedge clk); rst = 1'b1; #2;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_we", o_imem_we, 0);
    @(negedge clk); rst = 1'b0;
    s = {8'h4C, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    model(s); send(s, 0); drain();
    s = {8'h4C, 8'h00, 8'h01};
    for (int i = 0; i < 4 * CAP; i++) s.push_back(8'($urandom));
    model(s); send(s, 0); drain();
    for (int r = 0; r < 10; r++) begin
      s = {};
      repeat ($urandom_range(0, 2)) s.push_back(8'($urandom_range(0, 8'h4B)));
      n = (r == 9) ? int'($urandom_range(CAP + 1, 65535)) : int'($urandom_range(0, 6));
      s.push_back(8'h4C); s.push_back(n[7:0]); s.push_back(n[15:8]);
      if (n <= CAP) for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
      i_tx_full = $urandom_range(0, 1) == 1;
      model(s); send(s, -1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      @(negedge clk); i_tx_full = 1'b0;
      drain();
    end
    chk("queue_empty", exq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
